// File: rtl/mem_stage_hs.sv
// MIPS M stage with a variable-latency req/ack data-memory port.
// Drives byte lanes, extends load data, forwards store data from W and stalls upstream while waiting.
`timescale 1ns/1ps
module mem_stage_hs #(
    parameter logic [31:0] RESET_PC4 = 32'h0000_3004,
    parameter int          TIMEOUT   = 15,
    parameter int          ADDR_W    = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       IR_E2M,
    input  logic [31:0]       PC4_E2M,
    input  logic [31:0]       ALUout_E2M,
    input  logic [31:0]       RD2_E2M,
    input  logic              Valid_E2M,
    input  logic [4:0]        WhoNew_M2W,
    input  logic [31:0]       WD2A3,
    input  logic [31:0]       Mem_rdata,
    input  logic              Mem_ack,
    output logic              Mem_req,
    output logic              Mem_we,
    output logic [3:0]        Mem_be,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [31:0]       Mem_wdata,
    output logic              Stall_M,
    output logic [31:0]       IR_M2W,
    output logic [31:0]       PC4_M2W,
    output logic [31:0]       ALUout_M2W,
    output logic [31:0]       DMout_M2W,
    output logic              Valid_M2W,
    output logic [1:0]        Exc_M2W
);

    localparam logic [5:0] OP_LB = 6'b100000, OP_LH = 6'b100001, OP_LW = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100, OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB = 6'b101000, OP_SH = 6'b101001, OP_SW = 6'b101011;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             is_mem, is_store, is_unsigned, misaligned, start, done, to_hit;
    size_t            size;
    logic [1:0]       a;
    logic [31:0]      fwd, wdata_new, ld_data;
    logic [3:0]       be_new;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    // Holding registers for the access in flight
    logic [31:0]      h_ir, h_pc4, h_alu;
    size_t            h_size;
    logic             h_unsigned, h_store;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_mem      = 1'b1;
        is_store    = 1'b0;
        is_unsigned = 1'b0;
        size        = SZ_W;
        case (IR_E2M[31:26])
            OP_LB:   size = SZ_B;
            OP_LBU:  begin size = SZ_B; is_unsigned = 1'b1; end
            OP_LH:   size = SZ_H;
            OP_LHU:  begin size = SZ_H; is_unsigned = 1'b1; end
            OP_LW:   size = SZ_W;
            OP_SB:   begin size = SZ_B; is_store = 1'b1; end
            OP_SH:   begin size = SZ_H; is_store = 1'b1; end
            OP_SW:   begin size = SZ_W; is_store = 1'b1; end
            default: is_mem = 1'b0;
        endcase
    end

    assign a          = ALUout_E2M[1:0];
    assign fwd        = (IR_E2M[20:16] == WhoNew_M2W && IR_E2M[20:16] != 5'd0) ? WD2A3 : RD2_E2M;
    assign misaligned = is_mem && ((size == SZ_H && a[0]) || (size == SZ_W && a != 2'b00));
    assign start      = Valid_E2M && is_mem && !misaligned;

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = fwd;
        case (size)
            SZ_B:    begin be_new = 4'b0001 << a; wdata_new = {4{fwd[7:0]}}; end
            SZ_H:    begin be_new = a[1] ? 4'b1100 : 4'b0011; wdata_new = {2{fwd[15:0]}}; end
            default: ;
        endcase
    end

    always_comb begin
        case (h_alu[1:0])
            2'd0:    byte_sel = Mem_rdata[7:0];
            2'd1:    byte_sel = Mem_rdata[15:8];
            2'd2:    byte_sel = Mem_rdata[23:16];
            default: byte_sel = Mem_rdata[31:24];
        endcase
        half_sel = h_alu[1] ? Mem_rdata[31:16] : Mem_rdata[15:0];
        case (h_size)
            SZ_B:    ld_data = h_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    ld_data = h_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ld_data = Mem_rdata;
        endcase
    end

    // An ack in the last permitted WAIT cycle still completes normally
    assign to_hit = (cnt == CNT_LAST);
    assign done   = Mem_ack || to_hit;

    always_comb begin
        state_n = state;
        Stall_M = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                Stall_M = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                Stall_M = !done;
                if (done) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // NOTE: every flop here is a plain register, so all of them take the async reset; no array needs clearing.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            IR_M2W     <= '0;
            PC4_M2W    <= RESET_PC4;
            ALUout_M2W <= '0;
            DMout_M2W  <= '0;
            Valid_M2W  <= 1'b0;
            Exc_M2W    <= 2'b00;
            Mem_req    <= 1'b0;
            Mem_we     <= 1'b0;
            Mem_be     <= 4'b0000;
            Mem_addr   <= '0;
            Mem_wdata  <= '0;
            cnt        <= '0;
            h_ir       <= '0;
            h_pc4      <= '0;
            h_alu      <= '0;
            h_size     <= SZ_W;
            h_unsigned <= 1'b0;
            h_store    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt        <= '0;
                    PC4_M2W    <= PC4_E2M;
                    ALUout_M2W <= ALUout_E2M;
                    DMout_M2W  <= '0;
                    if (!Valid_E2M || start) begin
                        IR_M2W    <= '0;
                        Valid_M2W <= 1'b0;
                        Exc_M2W   <= 2'b00;
                    end else begin
                        IR_M2W    <= IR_E2M;
                        Valid_M2W <= 1'b1;
                        Exc_M2W   <= misaligned ? (is_store ? 2'b10 : 2'b01) : 2'b00;
                    end
                    if (start) begin
                        Mem_req    <= 1'b1;
                        Mem_we     <= is_store;
                        Mem_be     <= be_new;
                        Mem_addr   <= {ALUout_E2M[ADDR_W-1:2], 2'b00};
                        Mem_wdata  <= wdata_new;
                        h_ir       <= IR_E2M;
                        h_pc4      <= PC4_E2M;
                        h_alu      <= ALUout_E2M;
                        h_size     <= size;
                        h_unsigned <= is_unsigned;
                        h_store    <= is_store;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        Mem_req    <= 1'b0;
                        IR_M2W     <= h_ir;
                        PC4_M2W    <= h_pc4;
                        ALUout_M2W <= h_alu;
                        DMout_M2W  <= (Mem_ack && !h_store) ? ld_data : 32'd0;
                        Valid_M2W  <= 1'b1;
                        Exc_M2W    <= Mem_ack ? 2'b00 : 2'b11;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: directed vector table, reset-in-WAIT sequence,
// and randomized transactions checked against a behavioural model of the access rules.
`timescale 1ns/1ps
module tb_mem_stage_hs;

    localparam int TIMEOUT = 15;
    localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IR_E2M, PC4_E2M, ALUout_E2M, RD2_E2M, WD2A3, Mem_rdata;
    logic        Valid_E2M, Mem_ack;
    logic [4:0]  WhoNew_M2W;
    logic        Mem_req, Mem_we, Stall_M, Valid_M2W;
    logic [3:0]  Mem_be;
    logic [31:0] Mem_addr, Mem_wdata, IR_M2W, PC4_M2W, ALUout_M2W, DMout_M2W;
    logic [1:0]  Exc_M2W;

    mem_stage_hs #(.RESET_PC4(32'h0000_3004), .TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .IR_E2M(IR_E2M), .PC4_E2M(PC4_E2M), .ALUout_E2M(ALUout_E2M),
        .RD2_E2M(RD2_E2M), .Valid_E2M(Valid_E2M), .WhoNew_M2W(WhoNew_M2W), .WD2A3(WD2A3),
        .Mem_rdata(Mem_rdata), .Mem_ack(Mem_ack), .Mem_req(Mem_req), .Mem_we(Mem_we),
        .Mem_be(Mem_be), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata), .Stall_M(Stall_M),
        .IR_M2W(IR_M2W), .PC4_M2W(PC4_M2W), .ALUout_M2W(ALUout_M2W), .DMout_M2W(DMout_M2W),
        .Valid_M2W(Valid_M2W), .Exc_M2W(Exc_M2W)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // lat: WAIT cycle in which ack arrives (1 = first); 0 or > TIMEOUT means never
    typedef struct {
        logic        valid;
        logic [31:0] ir, alu, rd2;
        logic [4:0]  who;
        logic [31:0] wd, rdata;
        int          lat;
        logic        req;
        logic [3:0]  be;
        logic [31:0] wdata, dm;
        logic [1:0]  exc;
    } vec_t;

    function automatic logic [31:0] mk_ir(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd3, rt, 16'h0040};
    endfunction

    function automatic vec_t mkv(input logic valid, input logic [31:0] ir, alu, rd2,
                                 input logic [4:0] who, input logic [31:0] wd, rdata,
                                 input int lat, input logic req, input logic [3:0] be,
                                 input logic [31:0] wdata, dm, input logic [1:0] exc);
        vec_t v;
        v.valid = valid; v.ir = ir; v.alu = alu; v.rd2 = rd2; v.who = who; v.wd = wd;
        v.rdata = rdata; v.lat = lat; v.req = req; v.be = be; v.wdata = wdata; v.dm = dm;
        v.exc = exc;
        return v;
    endfunction

    // Expected results derived from the access rules with plain arithmetic
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int sz, a;
        logic store;
        logic [31:0] fwd, val, mask;
        a = int'(v.alu[1:0]);
        case (v.ir[31:26])
            LB, LBU, SB: sz = 1;
            LH, LHU, SH: sz = 2;
            LW, SW:      sz = 4;
            default:     sz = 0;
        endcase
        r.req = 1'b0; r.be = 4'b0; r.wdata = 32'b0; r.dm = 32'b0; r.exc = 2'b00;
        if (!v.valid || sz == 0) return r;
        store = v.ir[29];
        if (a % sz != 0) begin
            r.exc = store ? 2'b10 : 2'b01;
            return r;
        end
        r.req = 1'b1;
        r.be  = 4'(((1 << sz) - 1) << a);
        fwd   = (v.ir[20:16] == v.who && v.ir[20:16] != 5'd0) ? v.wd : v.rd2;
        if (sz == 1)      r.wdata = fwd[7:0] * 32'h0101_0101;
        else if (sz == 2) r.wdata = fwd[15:0] * 32'h0001_0001;
        else              r.wdata = fwd;
        if (v.lat == 0 || v.lat > TIMEOUT) begin
            r.exc = 2'b11;
            return r;
        end
        if (!store) begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
            val  = (v.rdata >> (8 * a)) & mask;
            if (!v.ir[28] && sz < 4 && val[8 * sz - 1]) val = val | ~mask;
            r.dm = val;
        end
        return r;
    endfunction

    // Presents one instruction from IDLE and follows it to its M2W write
    task automatic run_op(input vec_t v);
        logic [31:0] pc;
        bit          fin;
        pc         = {$urandom} & 32'hFFFF_FFFC;
        Valid_E2M  = v.valid;
        IR_E2M     = v.ir;
        PC4_E2M    = pc;
        ALUout_E2M = v.alu;
        RD2_E2M    = v.rd2;
        WhoNew_M2W = v.who;
        WD2A3      = v.wd;
        Mem_ack    = 1'b0;
        Mem_rdata  = $urandom;
        #1;
        check("stall_idle", Stall_M, v.req);
        check("req_idle", Mem_req, 0);
        @(posedge Clk); #1;
        if (!v.req) begin
            check("req_none", Mem_req, 0);
            check("valid_pass", Valid_M2W, v.valid);
            if (v.valid) begin
                check("ir_pass", IR_M2W, v.ir);
                check("pc4_pass", PC4_M2W, pc);
                check("alu_pass", ALUout_M2W, v.alu);
                check("dm_pass", DMout_M2W, v.dm);
                check("exc_pass", Exc_M2W, v.exc);
            end else begin
                check("ir_bubble", IR_M2W, 0);
            end
        end else begin
            fin = 1'b0;
            for (int k = 1; k <= TIMEOUT && !fin; k++) begin
                // W keeps moving; the latched store data must not follow it
                WD2A3      = $urandom;
                WhoNew_M2W = 5'($urandom);
                Mem_ack    = (k == v.lat);
                Mem_rdata  = Mem_ack ? v.rdata : $urandom;
                #1;
                check("req_wait", Mem_req, 1);
                check("we_wait", Mem_we, v.ir[29]);
                check("be_wait", Mem_be, v.be);
                check("addr_wait", Mem_addr, v.alu & 32'hFFFF_FFFC);
                check("wdata_wait", Mem_wdata, v.wdata);
                check("valid_wait", Valid_M2W, 0);
                check("stall_wait", Stall_M, !(Mem_ack || k == TIMEOUT));
                @(posedge Clk); #1;
                if (Mem_ack || k == TIMEOUT) fin = 1'b1;
            end
            Mem_ack = 1'b0;
            check("req_done", Mem_req, 0);
            check("valid_done", Valid_M2W, 1);
            check("ir_done", IR_M2W, v.ir);
            check("pc4_done", PC4_M2W, pc);
            check("alu_done", ALUout_M2W, v.alu);
            check("dm_done", DMout_M2W, v.dm);
            check("exc_done", Exc_M2W, v.exc);
        end
        Valid_E2M = 1'b0;
    endtask

    vec_t tbl[$];
    logic [5:0] ops[9] = '{LW, LB, LBU, LH, LHU, SW, SB, SH, 6'b000000};

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Valid_E2M = 1'b0; IR_E2M = '0; PC4_E2M = '0; ALUout_E2M = '0;
        RD2_E2M = '0; WhoNew_M2W = '0; WD2A3 = '0; Mem_rdata = '0; Mem_ack = 1'b0;
        #12;
        check("rst_ir", IR_M2W, 0);
        check("rst_pc4", PC4_M2W, 32'h0000_3004);
        check("rst_alu", ALUout_M2W, 0);
        check("rst_dm", DMout_M2W, 0);
        check("rst_valid", Valid_M2W, 0);
        check("rst_exc", Exc_M2W, 0);
        check("rst_req", Mem_req, 0);
        check("rst_we", Mem_we, 0);
        check("rst_be", Mem_be, 0);
        check("rst_stall", Stall_M, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        //          valid ir             alu     rd2           who wd            rdata         lat req be       wdata         dm            exc
        tbl.push_back(mkv(1, mk_ir(SW, 9),  32'h10, 32'hDEADBEEF, 0, 32'h0,        32'h0,        3,  1, 4'b1111, 32'hDEADBEEF, 32'h0,        2'b00));
        tbl.push_back(mkv(1, mk_ir(LB, 4),  32'h13, 32'h0,        0, 32'h0,        32'h80112233, 1,  1, 4'b1000, 32'h0,        32'hFFFFFF80, 2'b00));
        tbl.push_back(mkv(1, mk_ir(LBU, 4), 32'h13, 32'h0,        0, 32'h0,        32'h80112233, 1,  1, 4'b1000, 32'h0,        32'h00000080, 2'b00));
        tbl.push_back(mkv(1, mk_ir(SH, 5),  32'h12, 32'h1234,     5, 32'h5678,     32'h0,        2,  1, 4'b1100, 32'h56785678, 32'h0,        2'b00));
        tbl.push_back(mkv(1, mk_ir(LW, 6),  32'h06, 32'h0,        0, 32'h0,        32'h0,        1,  0, 4'b0000, 32'h0,        32'h0,        2'b01));
        tbl.push_back(mkv(1, mk_ir(LW, 6),  32'h20, 32'h0,        0, 32'h0,        32'h0,        0,  1, 4'b1111, 32'h0,        32'h0,        2'b11));
        tbl.push_back(mkv(1, 32'h00221820,  32'h42, 32'h0,        0, 32'h0,        32'h0,        1,  0, 4'b0000, 32'h0,        32'h0,        2'b00));
        tbl.push_back(mkv(1, mk_ir(LH, 2),  32'h02, 32'h0,        0, 32'h0,        32'h80017FFF, 1,  1, 4'b1100, 32'h0,        32'hFFFF8001, 2'b00));
        tbl.push_back(mkv(1, mk_ir(LHU, 2), 32'h00, 32'h0,        0, 32'h0,        32'h80017FFF, 2,  1, 4'b0011, 32'h0,        32'h00007FFF, 2'b00));
        tbl.push_back(mkv(1, mk_ir(SB, 7),  32'h01, 32'h000000AB, 0, 32'h0,        32'h0,        1,  1, 4'b0010, 32'hABABABAB, 32'h0,        2'b00));
        tbl.push_back(mkv(1, mk_ir(SH, 7),  32'h03, 32'h0,        0, 32'h0,        32'h0,        1,  0, 4'b0000, 32'h0,        32'h0,        2'b10));
        tbl.push_back(mkv(1, mk_ir(LW, 8),  32'h0C, 32'h0,        0, 32'h0,        32'h12345678, 15, 1, 4'b1111, 32'h0,        32'h12345678, 2'b00));
        tbl.push_back(mkv(1, mk_ir(SW, 0),  32'h08, 32'h11112222, 0, 32'hFFFF0000, 32'h0,        1,  1, 4'b1111, 32'h11112222, 32'h0,        2'b00));
        tbl.push_back(mkv(1, mk_ir(LB, 1),  32'h00, 32'h0,        0, 32'h0,        32'h0000007F, 1,  1, 4'b0001, 32'h0,        32'h0000007F, 2'b00));
        tbl.push_back(mkv(0, mk_ir(LW, 1),  32'h06, 32'h0,        0, 32'h0,        32'h0,        1,  0, 4'b0000, 32'h0,        32'h0,        2'b00));
        tbl.push_back(mkv(1, mk_ir(SW, 10), 32'h14, 32'hCAFEF00D, 11, 32'h0,       32'h0,        2,  1, 4'b1111, 32'hCAFEF00D, 32'h0,        2'b00));
        foreach (tbl[i]) run_op(tbl[i]);

        // Reset during the second WAIT cycle abandons the access
        Valid_E2M = 1'b1; IR_E2M = mk_ir(LW, 1); ALUout_E2M = 32'h30; PC4_E2M = 32'h100;
        Mem_ack = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("rstw_req_before", Mem_req, 1);
        Reset = 1'b1;
        #1;
        check("rstw_req", Mem_req, 0);
        check("rstw_valid", Valid_M2W, 0);
        check("rstw_ir", IR_M2W, 0);
        check("rstw_pc4", PC4_M2W, 32'h0000_3004);
        check("rstw_exc", Exc_M2W, 0);
        check("rstw_be", Mem_be, 0);
        Valid_E2M = 1'b0;
        #1;
        check("rstw_stall", Stall_M, 0);
        @(posedge Clk); #1;
        check("rstw_valid_held", Valid_M2W, 0);
        Reset = 1'b0;
        run_op(mkv(1, 32'h00221820, 32'h7, 32'h0, 0, 32'h0, 32'h0, 1, 0, 4'b0, 32'h0, 32'h0, 2'b00));

        for (int n = 0; n < 60; n++) begin
            vec_t v;
            v.valid = ($urandom_range(0, 9) != 0);
            v.ir    = {ops[$urandom_range(0, 8)], 5'($urandom), 5'($urandom_range(0, 3)), 16'($urandom)};
            v.alu   = $urandom & 32'h0000_0FFF;
            v.rd2   = $urandom;
            v.who   = 5'($urandom_range(0, 3));
            v.wd    = $urandom;
            v.rdata = $urandom;
            v.lat   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 1))
                                                  : int'($urandom_range(1, 3));
            run_op(model(v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
